// File: rtl/counter_modn_if.sv
// rtl/counter_modn_if.sv - control/status bundle for the modulo-N counter
//
// Purpose: groups the counter's control inputs and status outputs so that
//          the counter and its driver connect through one port.
// Signals:
//    clear       synchronous clear to 0
//    load        synchronous load of load_value (clamped when out of range)
//    load_value  value to load
//    enable      count-step enable
//    up          1 = count up, 0 = count down
//    sat         1 = saturate at bounds, 0 = wrap modulo MODULUS
//    q           registered count
//    tc          terminal count (combinational)
//    wrapped     one-cycle pulse when the count wrapped
//    load_err    one-cycle pulse when a load was out of range
//    at_max      q == MODULUS-1
//    at_zero     q == 0
// Modports: master drives controls and observes status; slave is the counter.

interface counter_modn_if #(
   parameter int WIDTH = 4
) ();
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             enable;
   logic             up;
   logic             sat;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrapped;
   logic             load_err;
   logic             at_max;
   logic             at_zero;

   modport master (
      output clear, load, load_value, enable, up, sat,
      input  q, tc, wrapped, load_err, at_max, at_zero
   );

   modport slave (
      input  clear, load, load_value, enable, up, sat,
      output q, tc, wrapped, load_err, at_max, at_zero
   );
endinterface

// File: rtl/counter_modn.sv
// rtl/counter_modn.sv - up/down modulo-N counter with load, clear and saturation
//
// Purpose: counts 0..MODULUS-1 up or down, wrapping or saturating at the
//          bounds. Per-cycle priority is clear > load > enable > hold.
// Parameters:
//    WIDTH        counter width in bits
//    MODULUS      count range 0..MODULUS-1 (2 <= MODULUS <= 2^WIDTH)
//    SAT_DEFAULT  intended saturation mode (0 or 1); no functional effect
// Ports:
//    clk    rising-edge clock
//    reset  asynchronous active-low reset
//    bus    counter_modn_if.slave control/status bundle

module counter_modn #(
   parameter int WIDTH       = 4,
   parameter int MODULUS     = 5,
   parameter int SAT_DEFAULT = 0
) (
   input logic           clk,
   input logic           reset,
   counter_modn_if.slave bus
);

   generate
      if (WIDTH < 1 || MODULUS < 2 ||
          longint'(MODULUS) > (longint'(1) << WIDTH) ||
          (SAT_DEFAULT != 0 && SAT_DEFAULT != 1)) begin : g_bad_params
         $error("counter_modn: illegal WIDTH/MODULUS/SAT_DEFAULT");
      end
   endgenerate

   // One extra bit so MODULUS == 2^WIDTH is representable in comparisons.
   localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);
   localparam logic [WIDTH:0] MAX_X = MOD_X - ONE_X;

   logic [WIDTH-1:0] q_r;
   logic             wrapped_r;
   logic             load_err_r;

   logic [WIDTH-1:0] q_next;
   logic             wrapped_next;
   logic             load_err_next;

   logic [WIDTH:0]   q_x;
   logic [WIDTH:0]   lv_x;
   logic [WIDTH:0]   inc_x;
   logic [WIDTH:0]   dec_x;
   logic             at_max;
   logic             at_zero;

   assign q_x     = {1'b0, q_r};
   assign lv_x    = {1'b0, bus.load_value};
   assign inc_x   = q_x + ONE_X;
   assign dec_x   = q_x - ONE_X;
   assign at_max  = (q_x == MAX_X);
   assign at_zero = (q_r == '0);

   always_comb begin
      q_next        = q_r;
      wrapped_next  = 1'b0;
      load_err_next = 1'b0;
      if (bus.clear) begin
         q_next = '0;
      end else if (bus.load) begin
         if (lv_x >= MOD_X) begin
            q_next        = MAX_X[WIDTH-1:0];
            load_err_next = 1'b1;
         end else begin
            q_next = bus.load_value;
         end
      end else if (bus.enable) begin
         if (bus.up) begin
            if (!at_max) begin
               q_next = inc_x[WIDTH-1:0];
            end else if (!bus.sat) begin
               q_next       = '0;
               wrapped_next = 1'b1;
            end
         end else begin
            if (!at_zero) begin
               q_next = dec_x[WIDTH-1:0];
            end else if (!bus.sat) begin
               q_next       = MAX_X[WIDTH-1:0];
               wrapped_next = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_r        <= '0;
         wrapped_r  <= 1'b0;
         load_err_r <= 1'b0;
      end else begin
         q_r        <= q_next;
         wrapped_r  <= wrapped_next;
         load_err_r <= load_err_next;
      end
   end

   assign bus.q        = q_r;
   assign bus.wrapped  = wrapped_r;
   assign bus.load_err = load_err_r;
   assign bus.at_max   = at_max;
   assign bus.at_zero  = at_zero;
   // Terminal count ignores sat: it flags the bound being hit, not the wrap.
   assign bus.tc       = bus.enable & ~bus.load & ~bus.clear &
                         (bus.up ? at_max : at_zero);

endmodule
